// File: rtl/melay_seq_10110_ov.sv
// Overlapping Mealy detector for the serial pattern 10110.
// Define MELAY_SEQ_REG_OUT_EN to register det_out (one cycle later, glitch-free).
module melay_seq_10110_ov (
  input  logic clk,
  input  logic rst,
  input  logic in_seq,
  output logic det_out
);

  typedef enum logic [2:0] {
    StS0 = 3'd0,
    StS1 = 3'd1,
    StS2 = 3'd2,
    StS3 = 3'd3,
    StS4 = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic   det_mealy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StS0;
    end else begin
      state_q <= state_d;
    end
  end

  // A match leaves "10" as the next prefix, so S4 on 0 goes to S2 rather than S0.
  always_comb begin
    state_d = StS0;
    case (state_q)
      StS0:    state_d = in_seq ? StS1 : StS0;
      StS1:    state_d = in_seq ? StS1 : StS2;
      StS2:    state_d = in_seq ? StS3 : StS0;
      StS3:    state_d = in_seq ? StS4 : StS2;
      StS4:    state_d = in_seq ? StS1 : StS2;
      default: state_d = StS0;
    endcase
  end

  always_comb begin
    det_mealy = (state_q == StS4) && !in_seq && rst;
  end

`ifdef MELAY_SEQ_REG_OUT_EN
  logic det_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      det_q <= 1'b0;
    end else begin
      det_q <= det_mealy;
    end
  end

  always_comb begin
    det_out = det_q;
  end
`else
  always_comb begin
    det_out = det_mealy;
  end
`endif

endmodule

// File: tb/tb_melay_seq_10110_ov.sv
// Self-checking bench for melay_seq_10110_ov: directed scenarios plus random stream,
// compared against a sliding-window model of the input history since reset.
module tb_melay_seq_10110_ov;

  logic clk = 1'b0;
  logic rst;
  logic in_seq;
  logic det_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: last five bits consumed since reset and how many have been consumed.
  logic [4:0] hist;
  int         n_seen;
  logic       reg_model;

  melay_seq_10110_ov dut (
    .clk     (clk),
    .rst     (rst),
    .in_seq  (in_seq),
    .det_out (det_out)
  );

  always #5 clk = ~clk;

  // Apply one bit/reset level for one cycle; return observed and expected det_out
  // sampled mid-cycle, then advance the model past the consuming edge.
  task automatic drive(input logic b, input logic r, output logic obs, output logic exp);
    logic [4:0] window;
    logic       match;
    in_seq = b;
    rst    = r;
    window = {hist[3:0], b};
    match  = r && (n_seen >= 4) && (window == 5'b10110);
`ifdef MELAY_SEQ_REG_OUT_EN
    exp = reg_model;
`else
    exp = match;
`endif
    @(negedge clk);
    obs = det_out;
    @(posedge clk);
    #1;
    if (!r) begin
      hist      = 5'b0;
      n_seen    = 0;
      reg_model = 1'b0;
    end else begin
      hist      = window;
      n_seen    = n_seen + 1;
      reg_model = match;
    end
  endtask

  task automatic test_reset();
    logic obs, exp;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, (i < 2) ? 1'b0 : 1'b1, obs, exp);
      n_tests++;
      if (obs !== exp || obs !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: det_out=%b expected=0", i, obs);
      end
    end
  endtask

  task automatic test_seq(input string name, input logic [15:0] bits, input int len,
                          input int want_hits);
    logic obs, exp;
    int   hits;
    hits = 0;
    for (int i = len - 1; i >= 0; i--) begin
      drive(bits[i], 1'b1, obs, exp);
      n_tests++;
      if (exp === 1'b1) hits++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s bit%0d: det_out=%b expected=%b", name, len - i, obs, exp);
      end
    end
    // Flush one idle cycle so a registered detect on the last bit is observed.
    drive(1'b0, 1'b1, obs, exp);
    n_tests++;
    if (exp === 1'b1) hits++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s flush: det_out=%b expected=%b", name, obs, exp);
    end
    n_tests++;
    if (hits != want_hits) begin
      n_fail++;
      $display("FAIL %s count: model_hits=%0d expected=%0d", name, hits, want_hits);
    end
  endtask

  task automatic test_reset_mid();
    logic       obs, exp;
    logic [3:0] pre;
    pre = 4'b1011;
    for (int i = 3; i >= 0; i--) drive(pre[i], 1'b1, obs, exp);
    // In S4 with in_seq=0 but rst low: output must stay gated.
    drive(1'b0, 1'b0, obs, exp);
    n_tests++;
    if (obs !== exp || obs !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid gate: det_out=%b expected=0", obs);
    end
    drive(1'b0, 1'b1, obs, exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_mid after: det_out=%b expected=%b", obs, exp);
    end
    test_seq("reset_mid_full", 16'b10110, 5, 1);
  endtask

  task automatic test_random();
    logic obs, exp;
    logic b, r;
    for (int i = 0; i < 400; i++) begin
      b = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
      drive(b, r, obs, exp);
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random[%0d] in=%b rst=%b: det_out=%b expected=%b", i, b, r, obs, exp);
      end
    end
  endtask

  initial begin
    rst       = 1'b0;
    in_seq    = 1'b0;
    hist      = 5'b0;
    n_seen    = 0;
    reg_model = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_seq("single", 16'b10110, 5, 1);
    test_seq("repeated", 16'b1011010110, 10, 2);
    test_seq("overlap", 16'b10110110, 8, 2);
    test_seq("near_10111", 16'b101110, 6, 0);
    test_seq("near_10100", 16'b10100, 5, 0);
    test_seq("near_then_match", 16'b1011110110, 10, 1);
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
